// File: rtl/safety_fault_escalator.sv
// Timed fault escalation IRQ -> NMI -> reset pulse -> lockout, stopped by software ack.
// Optional error-event counter is built only when SAFETY_ESC_ERR_CNT_EN is defined.
module safety_fault_escalator #(
   parameter int unsigned NMI_DELAY   = 1024,
   parameter int unsigned RST_DELAY   = 4096,
   parameter int unsigned RST_PULSE_W = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       wdg_timeout_i,
   input  logic       wdg_error_i,
   input  logic       fault_ack_i,
   input  logic       fault_clr_i,
   output logic       irq_o,
   output logic       nmi_o,
   output logic       rst_req_o,
   output logic [2:0] state_o,
   output logic [1:0] cause_o,
   output logic [7:0] err_cnt_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_IRQ   = 3'd1,
      ST_NMI   = 3'd2,
      ST_RESET = 3'd3,
      ST_LOCK  = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] NMI_LAST   = CNT_W'(NMI_DELAY - 1);
   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_DELAY - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_W - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic             irq_q, nmi_q, rst_req_q;
   logic             fault;

   assign fault = wdg_timeout_i | wdg_error_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      cause_d = cause_q;
      if (fault) begin
         cause_d = cause_q | {wdg_error_i, wdg_timeout_i};
      end
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (fault) begin
               state_d = ST_IRQ;
            end else if (fault_clr_i) begin
               cause_d = '0;
            end
         end
         // Ack is tested before expiry so it always wins the tie.
         ST_IRQ: begin
            if (fault_ack_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == NMI_LAST) begin
               state_d = ST_NMI;
               cnt_d   = '0;
            end
         end
         ST_NMI: begin
            if (fault_ack_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == RST_LAST) begin
               state_d = ST_RESET;
               cnt_d   = '0;
            end
         end
         ST_RESET: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = ST_LOCK;
               cnt_d   = '0;
            end
         end
         ST_LOCK: begin
            cnt_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_o.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cause_q   <= '0;
         irq_q     <= 1'b0;
         nmi_q     <= 1'b0;
         rst_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         irq_q     <= (state_d == ST_IRQ) || (state_d == ST_NMI);
         nmi_q     <= (state_d == ST_NMI);
         rst_req_q <= (state_d == ST_RESET);
      end
   end

   assign irq_o     = irq_q;
   assign nmi_o     = nmi_q;
   assign rst_req_o = rst_req_q;
   assign state_o   = state_q;
   assign cause_o   = cause_q;

`ifdef SAFETY_ESC_ERR_CNT_EN
   logic       err_q;
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == ST_IDLE) && fault_clr_i) begin
         err_cnt_d = 8'h00;
      end else if (wdg_error_i && !err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q     <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         err_q     <= wdg_error_i;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`else
   assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_safety_fault_escalator.sv
// Bench for safety_fault_escalator: directed scenarios plus random traffic against a stage/duration model.
module tb_safety_fault_escalator;

   localparam int NMI_D = 8;
   localparam int RST_D = 16;
   localparam int PW    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       to = 1'b0, er = 1'b0, ack = 1'b0, clr = 1'b0;
   logic       irq, nmi, rst_req;
   logic [2:0] state;
   logic [1:0] cause;
   logic [7:0] err_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: current stage and cycles spent in it.
   int         m_stage, m_el, m_errcnt;
   logic [1:0] m_cause;
   logic       m_prev_er;
   int         dur [0:4] = '{0, NMI_D, RST_D, PW, 0};

   safety_fault_escalator #(
      .NMI_DELAY(NMI_D), .RST_DELAY(RST_D), .RST_PULSE_W(PW), .CNT_W(16)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .wdg_timeout_i(to), .wdg_error_i(er),
      .fault_ack_i(ack), .fault_clr_i(clr),
      .irq_o(irq), .nmi_o(nmi), .rst_req_o(rst_req),
      .state_o(state), .cause_o(cause), .err_cnt_o(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ".irq"},   32'(irq),     32'(m_stage == 1 || m_stage == 2));
      chk({where, ".nmi"},   32'(nmi),     32'(m_stage == 2));
      chk({where, ".rst"},   32'(rst_req), 32'(m_stage == 3));
      chk({where, ".state"}, 32'(state),   32'(m_stage));
      chk({where, ".cause"}, 32'(cause),   32'(m_cause));
      chk({where, ".errcnt"}, 32'(err_cnt), 32'(m_errcnt));
   endtask

   task automatic model_reset();
      m_stage = 0; m_el = 0; m_cause = 2'b00; m_errcnt = 0; m_prev_er = 1'b0;
   endtask

   task automatic model_step();
`ifdef SAFETY_ESC_ERR_CNT_EN
      if (m_stage == 0 && clr) m_errcnt = 0;
      else if (er && !m_prev_er && m_errcnt < 255) m_errcnt++;
      m_prev_er = er;
`endif
      if (to || er) m_cause = m_cause | {er, to};
      case (m_stage)
         0: begin
            if (to || er) begin m_stage = 1; m_el = 0; end
            else if (clr) m_cause = 2'b00;
         end
         1, 2: begin
            if (ack) begin m_stage = 0; m_el = 0; end
            else if (m_el + 1 == dur[m_stage]) begin m_stage++; m_el = 0; end
            else m_el++;
         end
         3: begin
            if (m_el + 1 == dur[3]) begin m_stage = 4; m_el = 0; end
            else m_el++;
         end
         default: ;
      endcase
   endtask

   task automatic drive(input logic t, input logic e, input logic a, input logic c);
      to = t; er = e; ack = a; clr = c;
   endtask

   // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
   task automatic cycle(input string where);
      @(posedge clk);
      model_step();
      #1;
      check_all(where);
   endtask

   task automatic run(input int n, input string where);
      for (int i = 0; i < n; i++) cycle(where);
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
   task automatic async_reset(input string where);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(where);
      #1;
      rst_n = 1'b1;
   endtask

   int n_irq, n_nmi, n_rst;

   initial begin
      model_reset();
      #1;
      check_all("reset");
      @(posedge clk); #1;
      check_all("reset_hold");
      rst_n = 1'b1;
      run(2, "idle");

      // 1: timeout, never acked, full escalation to LOCK
      drive(1, 0, 0, 0);
      cycle("t1_entry");
      chk("t1_irq_rise", 32'(irq), 32'd1);
      drive(0, 0, 0, 0);
      n_irq = 1; n_nmi = 0; n_rst = 0;
      for (int i = 0; i < 34; i++) begin
         cycle("t1");
         n_irq += int'(irq); n_nmi += int'(nmi); n_rst += int'(rst_req);
      end
      chk("t1_irq_cycles", 32'(n_irq), 32'(NMI_D + RST_D));
      chk("t1_nmi_cycles", 32'(n_nmi), 32'(RST_D));
      chk("t1_rst_width",  32'(n_rst), 32'(PW));
      chk("t1_state_lock", 32'(state), 32'd4);
      chk("t1_cause",      32'(cause), 32'd1);

      // 5b: ack and clear have no effect in LOCK
      drive(0, 0, 1, 1);
      run(3, "t5_lock");
      chk("t5_lock_state", 32'(state), 32'd4);
      chk("t5_lock_cause", 32'(cause), 32'd1);
      drive(0, 0, 0, 0);
      async_reset("t5_lock_reset");

      // 2: one-cycle error, ack on IRQ cycle 3, then clear
      drive(0, 1, 0, 0);
      cycle("t2_entry");
      drive(0, 0, 0, 0);
      run(2, "t2_irq");
      drive(0, 0, 1, 0);
      cycle("t2_ack");
      chk("t2_state_idle", 32'(state), 32'd0);
      chk("t2_irq_drop",   32'(irq),   32'd0);
      chk("t2_cause_kept", 32'(cause), 32'd2);
      drive(0, 0, 0, 1);
      cycle("t2_clr");
      chk("t2_cause_clr",  32'(cause), 32'd0);
      drive(0, 0, 0, 0);

      // 3: ack coincides with NMI counter expiry
      drive(1, 0, 0, 0);
      cycle("t3_entry");
      drive(0, 0, 0, 0);
      run(NMI_D + RST_D - 1, "t3_run");
      chk("t3_in_nmi", 32'(state), 32'd2);
      drive(0, 0, 1, 0);
      cycle("t3_ack");
      drive(0, 0, 0, 0);
      n_rst = 0;
      for (int i = 0; i < 8; i++) begin
         cycle("t3_after");
         n_rst += int'(rst_req);
      end
      chk("t3_no_rst",   32'(n_rst), 32'd0);
      chk("t3_state",    32'(state), 32'd0);

      // 4: both faults held, ack in IRQ -> one IDLE cycle then IRQ again
      drive(1, 1, 0, 0);
      cycle("t4_entry");
      run(2, "t4_irq");
      drive(1, 1, 1, 0);
      cycle("t4_ack");
      chk("t4_idle", 32'(state), 32'd0);
      drive(1, 1, 0, 0);
      cycle("t4_reenter");
      chk("t4_irq_again", 32'(state), 32'd1);
      chk("t4_cause",     32'(cause), 32'd3);
      drive(0, 0, 1, 0);
      cycle("t4_ack2");
      drive(0, 0, 0, 1);
      cycle("t4_clr");

      // 5: reset asserted in the middle of the RESET pulse
      drive(1, 0, 0, 0);
      cycle("t5_entry");
      drive(0, 0, 0, 0);
      run(NMI_D + RST_D + 1, "t5_run");
      chk("t5_in_reset", 32'(rst_req), 32'd1);
      async_reset("t5_reset");
      chk("t5_rst_drop", 32'(rst_req), 32'd0);
      chk("t5_state0",   32'(state),   32'd0);

      // 6: many error pulses exercise the event counter and its saturation
      for (int i = 0; i < 300; i++) begin
         drive(0, 1, 0, 0);
         cycle("t6_pulse");
         drive(0, 0, 1, 0);
         cycle("t6_ack");
      end
      drive(0, 0, 0, 0);
      cycle("t6_end");
`ifdef SAFETY_ESC_ERR_CNT_EN
      chk("t6_errcnt_sat", 32'(err_cnt), 32'hFF);
`else
      chk("t6_errcnt_zero", 32'(err_cnt), 32'h00);
`endif
      drive(0, 0, 0, 1);
      cycle("t6_clr");

      // Random traffic with occasional mid-run resets
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
         if (($urandom_range(0, 3) == 0) && (i % 3 == 0)) begin
            drive(0, 0, 0, 0);
         end
         cycle("rand");
         if (i % 500 == 499) async_reset("rand_reset");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
